// File: rtl/id_ex_skid_pkg.sv
// Shared widths, control-bit positions and the ID/EX payload type.
// Optional macro ID_EX_WB_BYPASS_EN enables the writeback update of held operands.
package id_ex_skid_pkg;

    localparam int unsigned XLEN         = 32;
    localparam int unsigned RW           = 5;
    localparam int unsigned CTRL_W       = 8;
    localparam int unsigned CTRL_MEM_RD  = 0;
    localparam int unsigned CTRL_MEM_WR  = 1;
    localparam int unsigned CTRL_REG_WR  = 2;
    localparam int unsigned CTRL_ALU_LSB = 3;
    localparam int unsigned CTRL_ALU_MSB = 7;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [RW-1:0]     rs1;
        logic [RW-1:0]     rs2;
        logic [RW-1:0]     rd;
        logic [XLEN-1:0]   src1;
        logic [XLEN-1:0]   src2;
        logic [XLEN-1:0]   imm;
        logic [CTRL_W-1:0] ctrl;
    } id_ex_payload_t;

    // Replace stored operands whose source index matches a live writeback.
    function automatic id_ex_payload_t wb_bypass(input id_ex_payload_t p,
                                                 input logic [RW-1:0] wb_rd,
                                                 input logic [XLEN-1:0] wb_data);
        id_ex_payload_t r;
        r = p;
        if (wb_rd != '0 && p.rs1 == wb_rd) r.src1 = wb_data;
        if (wb_rd != '0 && p.rs2 == wb_rd) r.src2 = wb_data;
        return r;
    endfunction

endpackage

// File: rtl/id_ex_slot.sv
// One ID/EX payload register with load enable and optional writeback update.
// Macro ID_EX_WB_BYPASS_EN: held (and skid-forwarded) operands track writeback.
module id_ex_slot
    import id_ex_skid_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            d_byp,
    input  id_ex_payload_t  d,
    input  logic [RW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output id_ex_payload_t  q
);

    id_ex_payload_t nxt;

`ifdef ID_EX_WB_BYPASS_EN
    // d_byp marks an entry moving between slots; fresh ID data is already bypassed.
    always_comb begin
        nxt = q;
        if (load) nxt = d_byp ? wb_bypass(d, wb_rd, wb_data) : d;
        else      nxt = wb_bypass(q, wb_rd, wb_data);
    end
`else
    logic unused_wb;
    assign unused_wb = ^{wb_rd, wb_data, d_byp};

    always_comb begin
        nxt = q;
        if (load) nxt = d;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) q <= '0;
        else     q <= nxt;
    end

endmodule

// File: rtl/id_ex_skid.sv
// ID/EX pipeline register: two-slot skid buffer, load-use bubble and branch flush.
// Macro ID_EX_WB_BYPASS_EN (in id_ex_slot) enables writeback update of held operands.
module id_ex_skid
    import id_ex_skid_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [RW-1:0]     id_rs1,
    input  logic [RW-1:0]     id_rs2,
    input  logic [RW-1:0]     id_rd,
    input  logic [XLEN-1:0]   id_src1,
    input  logic [XLEN-1:0]   id_src2,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [XLEN-1:0]   ex_pc,
    output logic [RW-1:0]     ex_rs1,
    output logic [RW-1:0]     ex_rs2,
    output logic [RW-1:0]     ex_rd,
    output logic [XLEN-1:0]   ex_src1,
    output logic [XLEN-1:0]   ex_src2,
    output logic [XLEN-1:0]   ex_imm,
    output logic [CTRL_W-1:0] ex_ctrl,
    input  logic              flush,
    input  logic [RW-1:0]     wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    output logic              lu_stall
);

    id_ex_payload_t in_p, main_d, main_q, skid_q;
    logic           main_vld, skid_vld, bub;
    logic [RW-1:0]  ld_rd;
    logic           fire_in, fire_out, main_free, main_load, skid_load;
    logic           bub_hit, main_hit, main_is_load;

    assign in_p = '{pc: id_pc, rs1: id_rs1, rs2: id_rs2, rd: id_rd,
                    src1: id_src1, src2: id_src2, imm: id_imm, ctrl: id_ctrl};

    // Load-use detection against the load just issued (bub) and a load still in main.
    assign main_is_load = main_q.ctrl[CTRL_MEM_RD] & (main_q.rd != '0);
    assign bub_hit  = bub & (ld_rd != '0) & ((ld_rd == id_rs1) | (ld_rd == id_rs2));
    assign main_hit = main_vld & main_is_load &
                      ((main_q.rd == id_rs1) | (main_q.rd == id_rs2));
    assign lu_stall = id_valid & (bub_hit | main_hit);

    assign id_ready = ~rst & ~skid_vld & ~lu_stall & ~flush;
    assign fire_in  = id_valid & id_ready;
    assign fire_out = main_vld & ex_ready;

    assign main_free = ~main_vld | fire_out;
    assign main_load = main_free & (skid_vld | fire_in);
    assign skid_load = ~main_free & fire_in;
    assign main_d    = skid_vld ? skid_q : in_p;

    id_ex_slot u_main (
        .clk     (clk),
        .rst     (rst),
        .load    (main_load),
        .d_byp   (skid_vld),
        .d       (main_d),
        .wb_rd   (wb_rd),
        .wb_data (wb_data),
        .q       (main_q)
    );

    id_ex_slot u_skid (
        .clk     (clk),
        .rst     (rst),
        .load    (skid_load),
        .d_byp   (1'b0),
        .d       (in_p),
        .wb_rd   (wb_rd),
        .wb_data (wb_data),
        .q       (skid_q)
    );

    // Slot occupancy and the one-cycle load-use bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
            bub      <= 1'b0;
            ld_rd    <= '0;
        end else if (flush) begin
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
            bub      <= 1'b0;
        end else begin
            if (main_free) main_vld <= skid_vld | fire_in;
            if (main_free & skid_vld) skid_vld <= 1'b0;
            else if (skid_load)       skid_vld <= 1'b1;
            bub <= fire_out & main_is_load;
            if (fire_out) ld_rd <= main_q.rd;
        end
    end

    assign ex_valid = main_vld;
    assign ex_pc    = main_q.pc;
    assign ex_rs1   = main_q.rs1;
    assign ex_rs2   = main_q.rs2;
    assign ex_rd    = main_q.rd;
    assign ex_src1  = main_q.src1;
    assign ex_src2  = main_q.src2;
    assign ex_imm   = main_q.imm;
    assign ex_ctrl  = main_q.ctrl;

endmodule

// File: tb/tb_id_ex_skid.sv
// Directed self-checking bench for id_ex_skid; expectations follow ID_EX_WB_BYPASS_EN.
module tb_id_ex_skid;
    import id_ex_skid_pkg::*;

    logic              clk;
    logic              rst;
    logic              id_valid;
    logic              id_ready;
    logic [XLEN-1:0]   id_pc;
    logic [RW-1:0]     id_rs1, id_rs2, id_rd;
    logic [XLEN-1:0]   id_src1, id_src2, id_imm;
    logic [CTRL_W-1:0] id_ctrl;
    logic              ex_valid;
    logic              ex_ready;
    logic [XLEN-1:0]   ex_pc;
    logic [RW-1:0]     ex_rs1, ex_rs2, ex_rd;
    logic [XLEN-1:0]   ex_src1, ex_src2, ex_imm;
    logic [CTRL_W-1:0] ex_ctrl;
    logic              flush;
    logic [RW-1:0]     wb_rd;
    logic [XLEN-1:0]   wb_data;
    logic              lu_stall;

    int n_chk  = 0;
    int n_fail = 0;

    id_ex_skid dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_src1(id_src1), .id_src2(id_src2), .id_imm(id_imm), .id_ctrl(id_ctrl),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_pc(ex_pc), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_src1(ex_src1), .ex_src2(ex_src2), .ex_imm(ex_imm), .ex_ctrl(ex_ctrl),
        .flush(flush), .wb_rd(wb_rd), .wb_data(wb_data), .lu_stall(lu_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [CTRL_W-1:0] mk_ctrl(input logic [4:0] alu, input logic rw,
                                                  input logic mw, input logic mr);
        logic [CTRL_W-1:0] c;
        c = '0;
        c[CTRL_ALU_MSB:CTRL_ALU_LSB] = alu;
        c[CTRL_REG_WR] = rw;
        c[CTRL_MEM_WR] = mw;
        c[CTRL_MEM_RD] = mr;
        return c;
    endfunction

    task automatic offer(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rd, input logic [31:0] s1,
                         input logic [31:0] s2, input logic [CTRL_W-1:0] ctrl);
        id_valid = v;
        id_pc    = pc;
        id_rs1   = rs1;
        id_rs2   = rs2;
        id_rd    = rd;
        id_src1  = s1;
        id_src2  = s2;
        id_imm   = pc ^ 32'h0000_0F00;
        id_ctrl  = ctrl;
    endtask

    logic [31:0] exp_byp;

    initial begin
        rst = 1'b1; flush = 1'b0; ex_ready = 1'b0; wb_rd = '0; wb_data = '0;
        offer(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 8'h00);

        // Reset held two cycles
        tick(); tick();
        chk1("rst_ex_valid", ex_valid, 1'b0);
        chk1("rst_id_ready", id_ready, 1'b0);
        chk1("rst_ex_fields_zero",
             |{ex_pc, ex_rs1, ex_rs2, ex_rd, ex_src1, ex_src2, ex_imm, ex_ctrl}, 1'b0);
        rst = 1'b0;
        #1;
        chk1("post_rst_id_ready", id_ready, 1'b1);

        // Streaming: eight instructions, one per cycle
        ex_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            offer(1'b1, 32'(i * 4), 5'd0, 5'd0, 5'd1, 32'h0, 32'h0, mk_ctrl(5'd1, 1'b1, 1'b0, 1'b0));
            #1;
            chk1("stream_id_ready", id_ready, 1'b1);
            tick();
            chk1("stream_ex_valid", ex_valid, 1'b1);
            chk32("stream_ex_pc", ex_pc, 32'(i * 4));
        end
        id_valid = 1'b0;
        tick();
        chk1("stream_drained", ex_valid, 1'b0);

        // Backpressure: fill main then skid
        ex_ready = 1'b0;
        offer(1'b1, 32'h0, 5'd0, 5'd0, 5'd1, 32'h0, 32'h0, 8'h00);
        tick();
        offer(1'b1, 32'h4, 5'd0, 5'd0, 5'd1, 32'h0, 32'h0, 8'h00);
        #1;
        chk1("bp_skid_accept_ready", id_ready, 1'b1);
        tick();
        offer(1'b1, 32'h8, 5'd0, 5'd0, 5'd1, 32'h0, 32'h0, 8'h00);
        #1;
        chk1("bp_full_id_ready", id_ready, 1'b0);
        chk32("bp_main_pc", ex_pc, 32'h0);
        id_valid = 1'b0;
        ex_ready = 1'b1;
        tick();
        chk1("bp_second_valid", ex_valid, 1'b1);
        chk32("bp_second_pc", ex_pc, 32'h4);
        chk1("bp_skid_empty_ready", id_ready, 1'b1);
        tick();
        chk1("bp_drained", ex_valid, 1'b0);

        // Load-use: lw x5 then add x6,x5,x1
        offer(1'b1, 32'h40, 5'd2, 5'd0, 5'd5, 32'h0, 32'h0, mk_ctrl(5'd0, 1'b1, 1'b0, 1'b1));
        #1;
        chk1("lu_lw_no_stall", lu_stall, 1'b0);
        tick();
        chk32("lu_lw_in_ex", ex_pc, 32'h40);
        offer(1'b1, 32'h44, 5'd5, 5'd1, 5'd6, 32'h0, 32'h0, mk_ctrl(5'd2, 1'b1, 1'b0, 1'b0));
        #1;
        chk1("lu_main_stall", lu_stall, 1'b1);
        chk1("lu_main_ready", id_ready, 1'b0);
        tick();
        chk1("lu_bubble_ex_valid", ex_valid, 1'b0);
        chk1("lu_bubble_stall", lu_stall, 1'b1);
        chk1("lu_bubble_ready", id_ready, 1'b0);
        tick();
        chk1("lu_release_stall", lu_stall, 1'b0);
        chk1("lu_release_ready", id_ready, 1'b1);
        chk1("lu_release_ex_valid", ex_valid, 1'b0);
        tick();
        chk1("lu_add_valid", ex_valid, 1'b1);
        chk32("lu_add_pc", ex_pc, 32'h44);
        id_valid = 1'b0;
        tick();

        // Load to x0 never stalls
        offer(1'b1, 32'h50, 5'd2, 5'd0, 5'd0, 32'h0, 32'h0, mk_ctrl(5'd0, 1'b1, 1'b0, 1'b1));
        tick();
        offer(1'b1, 32'h54, 5'd0, 5'd0, 5'd6, 32'h0, 32'h0, mk_ctrl(5'd2, 1'b1, 1'b0, 1'b0));
        #1;
        chk1("x0_no_stall", lu_stall, 1'b0);
        chk1("x0_ready", id_ready, 1'b1);
        tick();
        chk32("x0_next_pc", ex_pc, 32'h54);
        id_valid = 1'b0;
        tick();

        // Flush with both slots full and a new instruction offered
        ex_ready = 1'b0;
        offer(1'b1, 32'h60, 5'd0, 5'd0, 5'd1, 32'h0, 32'h0, 8'h00);
        tick();
        offer(1'b1, 32'h64, 5'd0, 5'd0, 5'd1, 32'h0, 32'h0, 8'h00);
        tick();
        offer(1'b1, 32'h68, 5'd0, 5'd0, 5'd1, 32'h0, 32'h0, 8'h00);
        flush = 1'b1;
        #1;
        chk1("flush_id_ready", id_ready, 1'b0);
        tick();
        flush = 1'b0;
        id_valid = 1'b0;
        #1;
        chk1("flush_ex_valid", ex_valid, 1'b0);
        chk1("flush_skid_empty", id_ready, 1'b1);
        tick();
        chk1("flush_no_capture", ex_valid, 1'b0);

        // Writeback update of a held operand
        offer(1'b1, 32'h70, 5'd7, 5'd0, 5'd3, 32'h1111_1111, 32'h0, 8'h00);
        tick();
        id_valid = 1'b0;
        wb_rd = 5'd7;
        wb_data = 32'hDEAD_BEEF;
        #1;
        chk32("byp_before", ex_src1, 32'h1111_1111);
        tick();
        wb_rd = '0;
`ifdef ID_EX_WB_BYPASS_EN
        exp_byp = 32'hDEAD_BEEF;
`else
        exp_byp = 32'h1111_1111;
`endif
        chk32("byp_held_src1", ex_src1, exp_byp);

        // Incoming operand captured as presented even with a matching writeback
        offer(1'b1, 32'h74, 5'd0, 5'd9, 5'd3, 32'h0, 32'h2222_2222, 8'h00);
        wb_rd = 5'd9;
        wb_data = 32'h3333_3333;
        tick();
        id_valid = 1'b0;
        wb_rd = '0;
        ex_ready = 1'b1;
        tick();
        chk32("byp_incoming_pc", ex_pc, 32'h74);
        chk32("byp_incoming_src2", ex_src2, 32'h2222_2222);
        tick();
        chk1("final_drained", ex_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
